ms_elapsed_counter: RTL

- Sits directly downstream of the 1 ms timer and consumes its one-cycle timeOut pulse.
- Drives the timer's enable input.
- Measures elapsed milliseconds of a prime-search run between start and stop commands.
- Presents the result as a packed BCD value for the display path.

---
 rtl/ms_elapsed_counter_if.sv | 26 ++
 rtl/ms_elapsed_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ms_elapsed_counter_if.sv
// Control/status bundle between the prime-search sequencer and the elapsed-ms counter.
// The slave side is the counter; the master side drives start/stop/clear/tick.
interface ms_elapsed_counter_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  tick;
    logic                  timer_en;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   ms_bcd;
    logic                  overflow;
    logic                  timed_out;

    modport master (
        output start, stop, clear, tick,
        input  timer_en, busy, done, ms_bcd, overflow, timed_out
    );

    modport slave (
        input  start, stop, clear, tick,
        output timer_en, busy, done, ms_bcd, overflow, timed_out
    );
endinterface

// File: rtl/ms_elapsed_counter.sv
// Counts rising edges of the 1 ms tick between start and stop as packed BCD; outputs registered, count visible one edge after tick rises.
// ELAPSED_TIMEOUT_EN adds an auto-stop when the count reaches LIMIT_MS; otherwise timed_out stays 0.
module ms_elapsed_counter #(
    parameter int DIGITS   = 4,
    parameter int LIMIT_MS = 5000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    ms_elapsed_counter_if.slave     io_if
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_tick_q;
    logic [W-1:0]   r_bcd;
    logic [W-1:0]   w_bcd_nxt;
    logic [W-1:0]   w_bcd_inc;
    logic           r_overflow;
    logic           w_overflow_nxt;
    logic           r_timed_out;
    logic           w_timed_out_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_timer_en;
    logic           r_busy;
    logic           w_evt;
    logic           w_all9;
    logic           w_limit_hit;

    assign w_evt  = io_if.tick & ~r_tick_q;
    assign w_all9 = (r_bcd == ALL9);

    // Ripple-carry BCD increment: each digit wraps 9 -> 0 and passes the carry upward.
    always_comb begin
        logic w_carry;
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_carry) begin
                if (r_bcd[4*d +: 4] == 4'd9) begin
                    w_bcd_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

`ifdef ELAPSED_TIMEOUT_EN
    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  n;
        r = '0;
        n = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(n % 10);
            n           = n / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] LIMIT_BCD = to_bcd(LIMIT_MS);

    assign w_limit_hit = w_evt & ~w_all9 & (w_bcd_inc == LIMIT_BCD);
`else
    assign w_limit_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_bcd_nxt       = r_bcd;
        w_overflow_nxt  = r_overflow;
        w_timed_out_nxt = r_timed_out;
        w_done_nxt      = 1'b0;
        if (io_if.clear) begin
            w_state_nxt     = S_IDLE;
            w_bcd_nxt       = '0;
            w_overflow_nxt  = 1'b0;
            w_timed_out_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_if.start) begin
                        w_state_nxt     = S_RUN;
                        w_bcd_nxt       = '0;
                        w_overflow_nxt  = 1'b0;
                        w_timed_out_nxt = 1'b0;
                    end
                end
                S_RUN: begin
                    // The tick is applied before stop so a coincident edge is not lost.
                    if (w_evt) begin
                        if (w_all9) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_bcd_nxt = w_bcd_inc;
                        end
                    end
                    if (io_if.stop || w_limit_hit) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                    if (w_limit_hit) begin
                        w_timed_out_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_tick_q    <= 1'b0;
            r_bcd       <= '0;
            r_overflow  <= 1'b0;
            r_timed_out <= 1'b0;
            r_done      <= 1'b0;
            r_timer_en  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_q    <= io_if.tick;
            r_bcd       <= w_bcd_nxt;
            r_overflow  <= w_overflow_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_done      <= w_done_nxt;
            r_timer_en  <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_RUN);
        end
    end

    assign io_if.timer_en  = r_timer_en;
    assign io_if.busy      = r_busy;
    assign io_if.done      = r_done;
    assign io_if.ms_bcd    = r_bcd;
    assign io_if.overflow  = r_overflow;
    assign io_if.timed_out = r_timed_out;
endmodule
